// File: rtl/multi_digit_bcd_counter.sv
// Prescaled up/down BCD counter with synchronous load, wrap pulse and 7-segment decode.
// BCD is the count register itself (zero latency), SEG decodes it combinationally, TC is registered; no backpressure.
module multi_digit_bcd_counter #(
    parameter int DIGITS = 2,
    parameter int DIV    = 50000000
) (
    input  logic                  input_CLK,
    input  logic                  input_RST,
    input  logic                  input_ENA,
    input  logic                  input_UP,
    input  logic                  input_LOAD,
    input  logic [4*DIGITS-1:0]   input_DATA,
    output logic [4*DIGITS-1:0]   output_BCD,
    output logic [7*DIGITS-1:0]   output_SEG,
    output logic                  output_TC
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                tc_q, tc_d;

    logic                tick;
    logic [4*DIGITS-1:0] cnt_step;
    logic [4*DIGITS-1:0] load_val;
    logic                carry;
    logic [3:0]          dig;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign tick = input_ENA && (presc_q == PMAX);

    // Ripple the +1/-1 through the digits; carry surviving the last digit means a wrap.
    always_comb begin
        cnt_step = cnt_q;
        carry    = 1'b1;
        dig      = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = cnt_q[4*k +: 4];
            if (carry) begin
                if (input_UP) begin
                    if (dig >= 4'd9) begin
                        cnt_step[4*k +: 4] = 4'd0;
                    end else begin
                        cnt_step[4*k +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        cnt_step[4*k +: 4] = 4'd9;
                    end else begin
                        cnt_step[4*k +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        load_val = input_DATA;
        for (int k = 0; k < DIGITS; k++) begin
            if (input_DATA[4*k +: 4] > 4'd9) begin
                load_val[4*k +: 4] = 4'd0;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        presc_d = presc_q;
        tc_d    = 1'b0;
        if (input_LOAD) begin
            cnt_d   = load_val;
            presc_d = '0;
        end else if (tick) begin
            cnt_d   = cnt_step;
            presc_d = '0;
            tc_d    = carry;
        end else if (input_ENA) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge input_CLK) begin
        if (input_RST) begin
            cnt_q   <= '0;
            presc_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
        end
    end

    assign output_BCD = cnt_q;
    assign output_TC  = tc_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        assign output_SEG[7*g +: 7] = seg7(cnt_q[4*g +: 4]);
    end

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Directed bench: DIGITS=2/DIV=4 vector table plus a DIGITS=3/DIV=1 sweep against a decimal model.
module tb_multi_digit_bcd_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DIGITS=2, DIV=4
    logic        a_rst = 1'b1, a_ena = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [7:0]  a_data = 8'h00;
    logic [7:0]  a_bcd;
    logic [13:0] a_seg;
    logic        a_tc;

    // DUT B: DIGITS=3, DIV=1
    logic        b_rst = 1'b1, b_ena = 1'b0, b_up = 1'b1, b_load = 1'b0;
    logic [11:0] b_data = 12'h000;
    logic [11:0] b_bcd;
    logic [20:0] b_seg;
    logic        b_tc;

    multi_digit_bcd_counter #(.DIGITS(2), .DIV(4)) dut_a (
        .input_CLK(clk), .input_RST(a_rst), .input_ENA(a_ena), .input_UP(a_up),
        .input_LOAD(a_load), .input_DATA(a_data),
        .output_BCD(a_bcd), .output_SEG(a_seg), .output_TC(a_tc)
    );

    multi_digit_bcd_counter #(.DIGITS(3), .DIV(1)) dut_b (
        .input_CLK(clk), .input_RST(b_rst), .input_ENA(b_ena), .input_UP(b_up),
        .input_LOAD(b_load), .input_DATA(b_data),
        .output_BCD(b_bcd), .output_SEG(b_seg), .output_TC(b_tc)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       ena;
        logic       up;
        logic       load;
        logic [7:0] data;
        logic [7:0] bcd;
        logic       tc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] t [0:9];
        t[0] = 7'h3F; t[1] = 7'h06; t[2] = 7'h5B; t[3] = 7'h4F; t[4] = 7'h66;
        t[5] = 7'h6D; t[6] = 7'h7D; t[7] = 7'h07; t[8] = 7'h7F; t[9] = 7'h6F;
        return (d > 4'd9) ? 7'h00 : t[d];
    endfunction

    function automatic logic [11:0] to_bcd3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ena, input logic up, input logic load,
                       input logic [7:0] data, input logic [7:0] bcd, input logic tc, input int n);
        vec_t v;
        v.rst = rst; v.ena = ena; v.up = up; v.load = load;
        v.data = data; v.bcd = bcd; v.tc = tc;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst ena up load data bcd tc repeat
        add(1, 0, 1, 0, 8'h00, 8'h00, 0, 1);   // reset
        add(0, 0, 1, 1, 8'h98, 8'h98, 0, 1);   // load 98 with ENA low
        add(0, 1, 1, 0, 8'h00, 8'h98, 0, 3);
        add(0, 1, 1, 0, 8'h00, 8'h99, 0, 1);
        add(0, 1, 1, 0, 8'h00, 8'h99, 0, 3);
        add(0, 1, 1, 0, 8'h00, 8'h00, 1, 1);   // up wrap
        add(0, 1, 1, 0, 8'h00, 8'h00, 0, 3);
        add(0, 1, 1, 0, 8'h00, 8'h01, 0, 1);
        add(0, 0, 0, 1, 8'h00, 8'h00, 0, 1);   // load 00, no TC
        add(0, 1, 0, 0, 8'h00, 8'h00, 0, 3);
        add(0, 1, 0, 0, 8'h00, 8'h99, 1, 1);   // down wrap
        add(0, 1, 0, 0, 8'h00, 8'h99, 0, 3);
        add(0, 1, 0, 0, 8'h00, 8'h98, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h98, 0, 2);   // prescaler at 2
        add(0, 0, 0, 0, 8'h00, 8'h98, 0, 10);  // frozen
        add(0, 1, 0, 0, 8'h00, 8'h98, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h97, 0, 1);   // resumes after remaining cycles
        add(0, 1, 1, 1, 8'hA5, 8'h05, 0, 1);   // sanitised load
        add(0, 1, 1, 0, 8'h00, 8'h05, 0, 3);
        add(0, 1, 1, 1, 8'h42, 8'h42, 0, 1);   // load beats coincident tick
        add(0, 1, 1, 0, 8'h00, 8'h42, 0, 3);
        add(0, 1, 1, 0, 8'h00, 8'h43, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h43, 0, 3);   // direction change
        add(0, 1, 0, 0, 8'h00, 8'h42, 0, 1);
        add(0, 1, 1, 1, 8'h99, 8'h99, 0, 1);
        add(0, 1, 1, 0, 8'h00, 8'h99, 0, 3);
        add(0, 1, 1, 1, 8'h50, 8'h50, 0, 1);   // load on would-be wrap tick: no TC
        add(0, 0, 1, 1, 8'hFB, 8'h00, 0, 1);
        add(0, 0, 1, 1, 8'h9A, 8'h90, 0, 1);
        add(1, 1, 1, 1, 8'h77, 8'h00, 0, 1);   // reset beats load
        add(0, 1, 1, 0, 8'h00, 8'h00, 0, 2);   // partial interval
        add(1, 1, 1, 0, 8'h00, 8'h00, 0, 1);   // reset discards it
        add(0, 1, 1, 0, 8'h00, 8'h00, 0, 3);
        add(0, 1, 1, 0, 8'h00, 8'h01, 0, 1);

        foreach (vecs[i]) begin
            a_rst = vecs[i].rst; a_ena = vecs[i].ena; a_up = vecs[i].up;
            a_load = vecs[i].load; a_data = vecs[i].data;
            tick_edge();
            check($sformatf("vec%0d_bcd", i), 32'(a_bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_tc", i), 32'(a_tc), 32'(vecs[i].tc));
            check($sformatf("vec%0d_seg", i), 32'(a_seg),
                  32'({seg_ref(vecs[i].bcd[7:4]), seg_ref(vecs[i].bcd[3:0])}));
        end

        // 40 enabled up cycles from reset: 00..10, one step per 4 cycles
        a_rst = 1'b1; a_load = 1'b0; a_ena = 1'b0; a_up = 1'b1;
        tick_edge();
        check("rst_seg", 32'(a_seg), 32'h1FBF);
        a_rst = 1'b0; a_ena = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick_edge();
            check($sformatf("sweep%0d_bcd", i), 32'(a_bcd),
                  32'({4'((i / 4) / 10), 4'((i / 4) % 10)}));
            check($sformatf("sweep%0d_tc", i), 32'(a_tc), 32'd0);
            if (i == 4) check("seg_01", 32'(a_seg), 32'h1F86);
        end
        a_ena = 1'b0;

        // DUT B: wrap from 999 in one cycle, then full sweeps against a decimal model
        b_rst = 1'b0; b_load = 1'b1; b_data = 12'h999;
        tick_edge();
        check("b_load999", 32'(b_bcd), 32'h999);
        b_load = 1'b0; b_ena = 1'b1; b_up = 1'b1;
        tick_edge();
        check("b_wrap_bcd", 32'(b_bcd), 32'h000);
        check("b_wrap_tc", 32'(b_tc), 32'd1);
        b_ena = 1'b0; b_rst = 1'b1;
        tick_edge();
        check("b_rst_bcd", 32'(b_bcd), 32'h000);
        b_rst = 1'b0; b_ena = 1'b1;
        begin
            int m;
            m = 0;
            for (int i = 0; i < 1000; i++) begin
                tick_edge();
                m = (m + 1) % 1000;
                check($sformatf("b_up%0d_bcd", i), 32'(b_bcd), 32'(to_bcd3(m)));
                check($sformatf("b_up%0d_tc", i), 32'(b_tc), 32'(m == 0));
            end
            b_up = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick_edge();
                m = (m + 999) % 1000;
                check($sformatf("b_dn%0d_bcd", i), 32'(b_bcd), 32'(to_bcd3(m)));
                check($sformatf("b_dn%0d_tc", i), 32'(b_tc), 32'(m == 999));
            end
        end
        check("b_seg", 32'(b_seg),
              32'({seg_ref(b_bcd[11:8]), seg_ref(b_bcd[7:4]), seg_ref(b_bcd[3:0])}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
